// File: rtl/vnp4_ingress_arbiter.sv
// Packet-level round-robin arbiter sharing one Vitis Net P4 input stream among NUM_PORT requesters.
// Optional per-port accepted-packet counters (pkt_count) are built when ARB_STATS_EN is defined.
module vnp4_ingress_arbiter #(
  parameter int NUM_PORT = 4,
  parameter int DATA_W   = 512,
  parameter int SIZE_W   = 16,
  parameter int PORT_W   = 16
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [NUM_PORT*DATA_W-1:0]   s_tdata,
  input  logic [NUM_PORT*DATA_W/8-1:0] s_tkeep,
  input  logic [NUM_PORT-1:0]          s_tlast,
  input  logic [NUM_PORT*SIZE_W-1:0]   s_tuser_size,
  input  logic [NUM_PORT-1:0]          s_tvalid,
  output logic [NUM_PORT-1:0]          s_tready,
  output logic [DATA_W-1:0]            m_tdata,
  output logic [DATA_W/8-1:0]          m_tkeep,
  output logic                         m_tlast,
  output logic                         m_tvalid,
  input  logic                         m_tready,
  output logic [SIZE_W-1:0]            m_user_size,
  output logic [PORT_W-1:0]            m_user_ingress_port,
  output logic                         m_user_valid,
  output logic                         idle
`ifdef ARB_STATS_EN
  ,
  output logic [NUM_PORT*32-1:0]       pkt_count
`endif
);
  localparam int KEEP_W = DATA_W / 8;
  localparam int IDX_W  = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1;

  typedef enum logic {ST_IDLE, ST_PASS} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               first_beat_q, first_beat_d;
  logic [DATA_W-1:0]  m_tdata_q, m_tdata_d;
  logic [KEEP_W-1:0]  m_tkeep_q, m_tkeep_d;
  logic               m_tlast_q, m_tlast_d;
  logic               m_tvalid_q, m_tvalid_d;
  logic [SIZE_W-1:0]  m_user_size_q, m_user_size_d;
  logic [PORT_W-1:0]  m_user_port_q, m_user_port_d;
  logic               m_user_valid_q, m_user_valid_d;

  logic [DATA_W-1:0]  tdata_a [NUM_PORT];
  logic [KEEP_W-1:0]  tkeep_a [NUM_PORT];
  logic [SIZE_W-1:0]  tsize_a [NUM_PORT];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORT; gi++) begin : g_unpack
      assign tdata_a[gi] = s_tdata[gi*DATA_W +: DATA_W];
      assign tkeep_a[gi] = s_tkeep[gi*KEEP_W +: KEEP_W];
      assign tsize_a[gi] = s_tuser_size[gi*SIZE_W +: SIZE_W];
    end
  endgenerate

  // First valid requester at or after rr_ptr, wrapping at NUM_PORT-1.
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W:0]   cand;
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = rr_ptr_q;
    cand       = '0;
    for (int k = 0; k < NUM_PORT; k++) begin
      cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_PORT)) cand = cand - (IDX_W+1)'(NUM_PORT);
      if (!pick_found && s_tvalid[cand[IDX_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IDX_W-1:0];
      end
    end
  end

  logic [IDX_W:0]   next_ptr_w;
  logic [IDX_W-1:0] next_ptr;
  always_comb begin
    next_ptr_w = {1'b0, grant_q} + (IDX_W+1)'(1);
    if (next_ptr_w >= (IDX_W+1)'(NUM_PORT)) next_ptr_w = '0;
    next_ptr = next_ptr_w[IDX_W-1:0];
  end

  logic pass_ready;
  logic accept;
  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    rr_ptr_d       = rr_ptr_q;
    first_beat_d   = first_beat_q;
    s_tready       = '0;
    pass_ready     = 1'b0;
    accept         = 1'b0;
    m_tdata_d      = m_tdata_q;
    m_tkeep_d      = m_tkeep_q;
    m_tlast_d      = m_tlast_q;
    m_tvalid_d     = m_tvalid_q;
    m_user_size_d  = m_user_size_q;
    m_user_port_d  = m_user_port_q;
    m_user_valid_d = m_user_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d      = pick_idx;
          first_beat_d = 1'b1;
          state_d      = ST_PASS;
        end
      end
      ST_PASS: begin
        pass_ready        = !m_tvalid_q || m_tready;
        s_tready[grant_q] = pass_ready;
        accept            = s_tvalid[grant_q] && pass_ready;
        if (accept) begin
          first_beat_d = 1'b0;
          if (s_tlast[grant_q]) begin
            rr_ptr_d = next_ptr;
            state_d  = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Output slice: load on accept, drain when the core takes the beat.
    if (accept) begin
      m_tdata_d      = tdata_a[grant_q];
      m_tkeep_d      = tkeep_a[grant_q];
      m_tlast_d      = s_tlast[grant_q];
      m_tvalid_d     = 1'b1;
      m_user_size_d  = tsize_a[grant_q];
      m_user_port_d  = PORT_W'(grant_q);
      m_user_valid_d = first_beat_q;
    end else if (m_tready) begin
      m_tvalid_d     = 1'b0;
      m_user_valid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q        <= ST_IDLE;
      grant_q        <= '0;
      rr_ptr_q       <= '0;
      first_beat_q   <= 1'b0;
      m_tdata_q      <= '0;
      m_tkeep_q      <= '0;
      m_tlast_q      <= 1'b0;
      m_tvalid_q     <= 1'b0;
      m_user_size_q  <= '0;
      m_user_port_q  <= '0;
      m_user_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      rr_ptr_q       <= rr_ptr_d;
      first_beat_q   <= first_beat_d;
      m_tdata_q      <= m_tdata_d;
      m_tkeep_q      <= m_tkeep_d;
      m_tlast_q      <= m_tlast_d;
      m_tvalid_q     <= m_tvalid_d;
      m_user_size_q  <= m_user_size_d;
      m_user_port_q  <= m_user_port_d;
      m_user_valid_q <= m_user_valid_d;
    end
  end

  assign m_tdata             = m_tdata_q;
  assign m_tkeep             = m_tkeep_q;
  assign m_tlast             = m_tlast_q;
  assign m_tvalid            = m_tvalid_q;
  assign m_user_size         = m_user_size_q;
  assign m_user_ingress_port = m_user_port_q;
  assign m_user_valid        = m_user_valid_q;
  assign idle                = (state_q == ST_IDLE) && !m_tvalid_q;

`ifdef ARB_STATS_EN
  generate
    for (gi = 0; gi < NUM_PORT; gi++) begin : g_stats
      logic [31:0] cnt_q, cnt_d;
      always_comb begin
        cnt_d = cnt_q;
        if (accept && s_tlast[grant_q] && (grant_q == IDX_W'(gi))) cnt_d = cnt_q + 32'd1;
      end
      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) cnt_q <= '0;
        else          cnt_q <= cnt_d;
      end
      assign pkt_count[gi*32 +: 32] = cnt_q;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_vnp4_ingress_arbiter.sv
// Self-checking bench for vnp4_ingress_arbiter: packet-level reference model plus directed scenarios.
module tb_vnp4_ingress_arbiter;
  localparam int NP = 4;
  localparam int DW = 32;
  localparam int KW = DW / 8;
  localparam int SW = 16;
  localparam int PW = 16;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic [NP*DW-1:0]  s_tdata = '0;
  logic [NP*KW-1:0]  s_tkeep = '0;
  logic [NP-1:0]     s_tlast = '0;
  logic [NP*SW-1:0]  s_tuser_size = '0;
  logic [NP-1:0]     s_tvalid = '0;
  logic [NP-1:0]     s_tready;
  logic [DW-1:0]     m_tdata;
  logic [KW-1:0]     m_tkeep;
  logic              m_tlast;
  logic              m_tvalid;
  logic              m_tready = 1'b0;
  logic [SW-1:0]     m_user_size;
  logic [PW-1:0]     m_user_ingress_port;
  logic              m_user_valid;
  logic              idle;
`ifdef ARB_STATS_EN
  logic [NP*32-1:0]  pkt_count;
`endif

  vnp4_ingress_arbiter #(.NUM_PORT(NP), .DATA_W(DW), .SIZE_W(SW), .PORT_W(PW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tuser_size(s_tuser_size),
    .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .m_user_size(m_user_size), .m_user_ingress_port(m_user_ingress_port),
    .m_user_valid(m_user_valid), .idle(idle)
`ifdef ARB_STATS_EN
    , .pkt_count(pkt_count)
`endif
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [SW-1:0] size;
    int            port;
    logic          first;
  } beat_t;

  typedef struct {
    int            cyc;
    int            port;
    logic          last;
    logic [DW-1:0] data;
  } in_rec_t;

  int checks = 0;
  int errors = 0;

  // Source state: pending packet descriptors and the beat currently presented.
  int            pend_len  [NP][$];
  int            pend_size [NP][$];
  bit            act  [NP];
  bit            pres [NP];
  int            beat_i [NP];
  int            len  [NP];
  logic [SW-1:0] sz   [NP];
  logic [DW-1:0] cd   [NP];
  logic [KW-1:0] ck   [NP];

  // Reference model: packet-level arbiter plus one-deep output slice as a queue.
  bit    busy;
  int    mgrant;
  int    mptr;
  beat_t oq[$];

  beat_t         out_log[$];
  in_rec_t       in_log[$];
  logic [NP-1:0] tv_log[$];
  logic [NP-1:0] tr_log[$];
  int            cyc;
  int            rmode;
  int            vprob;

  task automatic chk(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act_v, exp_v, $time);
    end
  endtask

  function automatic int pick(input logic [NP-1:0] v);
    for (int k = 0; k < NP; k++)
      if (v[(mptr + k) % NP]) return (mptr + k) % NP;
    return 0;
  endfunction

  function automatic bit all_done();
    bit d;
    d = !busy && (oq.size() == 0);
    for (int p = 0; p < NP; p++)
      if (act[p] || pres[p] || pend_len[p].size() != 0) d = 0;
    return d;
  endfunction

  task automatic clear_model();
    busy = 0; mgrant = 0; mptr = 0;
    oq.delete();
    for (int p = 0; p < NP; p++) begin
      act[p] = 0; pres[p] = 0; beat_i[p] = 0; len[p] = 0; sz[p] = '0; cd[p] = '0; ck[p] = '0;
      pend_len[p].delete(); pend_size[p].delete();
    end
  endtask

  task automatic start_scn(input int rm, input int vp);
    out_log.delete(); in_log.delete(); tv_log.delete(); tr_log.delete();
    cyc = 0; rmode = rm; vprob = vp;
  endtask

  task automatic add_pkt(input int p, input int l, input int s);
    pend_len[p].push_back(l);
    pend_size[p].push_back(s);
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic step();
    logic [NP-1:0] in_acc;
    logic [NP-1:0] exp_rdy;
    bit            out_acc;
    beat_t         b;
    for (int p = 0; p < NP; p++) begin
      if (!pres[p]) begin
        if (!act[p] && pend_len[p].size() != 0 && int'($urandom_range(0, 99)) < vprob) begin
          act[p] = 1; beat_i[p] = 0;
          len[p] = pend_len[p].pop_front();
          sz[p]  = SW'(pend_size[p].pop_front());
        end
        if (act[p] && int'($urandom_range(0, 99)) < vprob) begin
          pres[p] = 1;
          cd[p]   = $urandom;
          ck[p]   = ($urandom_range(0, 7) == 0) ? '0 : KW'($urandom);
        end
      end
      s_tvalid[p]                 = pres[p];
      s_tlast[p]                  = pres[p] && (beat_i[p] == len[p] - 1);
      s_tdata[p*DW +: DW]         = cd[p];
      s_tkeep[p*KW +: KW]         = ck[p];
      s_tuser_size[p*SW +: SW]    = sz[p];
    end
    case (rmode)
      0:       m_tready = 1'b1;
      1:       m_tready = (cyc % 2 == 0);
      default: m_tready = ($urandom_range(0, 3) != 0);
    endcase
    #1;
    exp_rdy = '0;
    if (busy && (oq.size() == 0 || m_tready)) exp_rdy[mgrant] = 1'b1;
    chk("s_tready", 64'(s_tready), 64'(exp_rdy));
    chk("m_tvalid", 64'(m_tvalid), 64'(oq.size() != 0));
    chk("idle", 64'(idle), 64'(!busy && oq.size() == 0));
    if (oq.size() != 0 && m_tvalid) begin
      b = oq[0];
      chk("m_tdata", 64'(m_tdata), 64'(b.data));
      chk("m_tkeep", 64'(m_tkeep), 64'(b.keep));
      chk("m_tlast", 64'(m_tlast), 64'(b.last));
      chk("m_user_size", 64'(m_user_size), 64'(b.size));
      chk("m_user_ingress_port", 64'(m_user_ingress_port), 64'(b.port));
      chk("m_user_valid", 64'(m_user_valid), 64'(b.first));
    end
    tv_log.push_back(s_tvalid);
    tr_log.push_back(s_tready);
    out_acc = m_tvalid && m_tready;
    if (out_acc) begin
      out_log.push_back('{m_tdata, m_tkeep, m_tlast, m_user_size, int'(m_user_ingress_port), m_user_valid});
      if (oq.size() != 0) void'(oq.pop_front());
    end
    in_acc = s_tvalid & s_tready;
    if (busy) begin
      if (in_acc[mgrant] && s_tlast[mgrant]) begin
        busy = 0;
        mptr = (mgrant + 1) % NP;
      end
    end else if (s_tvalid != '0) begin
      busy   = 1;
      mgrant = pick(s_tvalid);
    end
    for (int p = 0; p < NP; p++) begin
      if (in_acc[p]) begin
        oq.push_back('{cd[p], ck[p], s_tlast[p], sz[p], p, (beat_i[p] == 0)});
        in_log.push_back('{cyc, p, s_tlast[p], cd[p]});
        pres[p] = 0;
        beat_i[p]++;
        if (beat_i[p] == len[p]) act[p] = 0;
      end
    end
    cyc++;
    @(negedge aclk);
  endtask

  task automatic run_until_done(input int maxc);
    int n;
    n = 0;
    while (!all_done() && n < maxc) begin
      step();
      n++;
    end
    chk("run_timeout", 64'(n >= maxc), 64'(0));
    repeat (2) step();
  endtask

  // Asynchronous reset: outputs checked 1 ns after assertion, away from any clock edge.
  task automatic do_reset();
    aresetn = 1'b0;
    s_tvalid = '0; s_tlast = '0; s_tdata = '0; s_tkeep = '0; s_tuser_size = '0;
    m_tready = 1'b0;
    #1;
    chk("rst_m_tvalid", 64'(m_tvalid), 64'(0));
    chk("rst_m_tlast", 64'(m_tlast), 64'(0));
    chk("rst_m_user_valid", 64'(m_user_valid), 64'(0));
    chk("rst_m_tdata", 64'(m_tdata), 64'(0));
    chk("rst_m_tkeep", 64'(m_tkeep), 64'(0));
    chk("rst_m_user_size", 64'(m_user_size), 64'(0));
    chk("rst_m_user_port", 64'(m_user_ingress_port), 64'(0));
    chk("rst_s_tready", 64'(s_tready), 64'(0));
    chk("rst_idle", 64'(idle), 64'(1));
`ifdef ARB_STATS_EN
    for (int p = 0; p < NP; p++) chk("rst_pkt_count", 64'(pkt_count[p*32 +: 32]), 64'(0));
`endif
    clear_model();
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, rc, rfirst, rlast, flags, lasts;
    clear_model();
    start_scn(0, 100);
    @(negedge aclk);
    do_reset();

    // A: port 2, 3-beat packet, size 150.
    start_scn(0, 100);
    add_pkt(2, 3, 150);
    run_until_done(100);
    c0 = -1; rc = 0; rfirst = -1; rlast = -1;
    for (int i = 0; i < tv_log.size(); i++) begin
      if (c0 < 0 && tv_log[i][2]) c0 = i;
      if (tr_log[i][2]) begin
        rc++;
        if (rfirst < 0) rfirst = i;
        rlast = i;
      end
    end
    chk("A_ready_cycles", 64'(rc), 64'(3));
    chk("A_ready_start", 64'(rfirst), 64'(c0 + 1));
    chk("A_ready_end", 64'(rlast), 64'(c0 + 3));
    chk("A_out_beats", 64'(out_log.size()), 64'(3));
    if (out_log.size() == 3) begin
      flags = 0; lasts = 0;
      for (int i = 0; i < 3; i++) begin
        chk("A_port", 64'(out_log[i].port), 64'(2));
        chk("A_size", 64'(out_log[i].size), 64'(150));
        flags = flags * 2 + int'(out_log[i].first);
        lasts = lasts * 2 + int'(out_log[i].last);
      end
      chk("A_user_valid_pattern", 64'(flags), 64'(4));
      chk("A_tlast_pattern", 64'(lasts), 64'(1));
    end

    // B: all ports continuously valid, two 2-beat packets each.
    do_reset();
    start_scn(0, 100);
    for (int p = 0; p < NP; p++) begin
      add_pkt(p, 2, 100 + p);
      add_pkt(p, 2, 200 + p);
    end
    run_until_done(200);
    chk("B_out_beats", 64'(out_log.size()), 64'(16));
    for (int i = 0; i < out_log.size() && i < 16; i++)
      chk("B_grant_order", 64'(out_log[i].port), 64'((i / 2) % 4));
    for (int j = 0; j + 1 < in_log.size(); j++)
      chk("B_gap", 64'(in_log[j+1].cyc - in_log[j].cyc), 64'(in_log[j].last ? 2 : 1));

    // C: 5-beat packet with m_tready toggling every cycle.
    do_reset();
    start_scn(1, 100);
    add_pkt(0, 5, 300);
    run_until_done(100);
    chk("C_out_beats", 64'(out_log.size()), 64'(5));
    if (out_log.size() == 5 && in_log.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        chk("C_data_order", 64'(out_log[i].data), 64'(in_log[i].data));
        chk("C_tlast", 64'(out_log[i].last), 64'(i == 4));
      end
    end

    // D: single-beat packet on port 1 races port 3.
    do_reset();
    start_scn(0, 100);
    add_pkt(1, 1, 64);
    add_pkt(3, 1, 128);
    run_until_done(100);
    chk("D_out_beats", 64'(out_log.size()), 64'(2));
    if (out_log.size() == 2) begin
      chk("D_first_port", 64'(out_log[0].port), 64'(1));
      chk("D_first_valid_last", 64'({out_log[0].first, out_log[0].last}), 64'(3));
      chk("D_second_port", 64'(out_log[1].port), 64'(3));
    end

    // E: reset during beat 2 of a 4-beat packet, after rr_ptr has moved to 1.
    do_reset();
    start_scn(0, 100);
    add_pkt(0, 1, 60);
    run_until_done(100);
    add_pkt(1, 4, 200);
    rc = 0;
    while (in_log.size() < 2 && rc < 50) begin
      step();
      rc++;
    end
    chk("E_beat1_pending", 64'(m_tvalid), 64'(1));
    do_reset();
    start_scn(0, 100);
    for (int p = 0; p < NP; p++) add_pkt(p, 1, 40 + p);
    run_until_done(100);
    chk("E_out_beats", 64'(out_log.size()), 64'(4));
    if (out_log.size() != 0) chk("E_first_grant", 64'(out_log[0].port), 64'(0));

    // F: randomized traffic, gaps and backpressure.
    do_reset();
    start_scn(2, 60);
    for (int p = 0; p < NP; p++)
      for (int n = 0; n < 10; n++)
        add_pkt(p, int'($urandom_range(1, 6)), int'($urandom_range(1, 9000)));
    run_until_done(5000);
    chk("F_out_beats", 64'(out_log.size()), 64'(in_log.size()));

`ifdef ARB_STATS_EN
    // G: per-port packet counters.
    do_reset();
    start_scn(0, 100);
    for (int n = 0; n < 3; n++) add_pkt(0, 2, 70);
    add_pkt(3, 1, 80);
    run_until_done(200);
    chk("G_count0", 64'(pkt_count[0 +: 32]), 64'(3));
    chk("G_count1", 64'(pkt_count[32 +: 32]), 64'(0));
    chk("G_count2", 64'(pkt_count[64 +: 32]), 64'(0));
    chk("G_count3", 64'(pkt_count[96 +: 32]), 64'(1));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
